// File: rtl/mul_channel_scheduler_pkg.sv
// Shared types and helpers for the multiplexed multiplier scheduler.
package mul_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_LO,
        WAIT_HI,
        STORE,
        DONE
    } state_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Round half-up, arithmetic shift, clamp to a width_o signed range.
    // 64-bit internals keep the rounding add from wrapping for any product up to 63 bits.
    function automatic rs_t round_sat(input logic signed [63:0] y,
                                      input int unsigned        shift,
                                      input int unsigned        width_o);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_t                res;
        r  = (y + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (width_o - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width_o - 1));
        res.sat = (r > hi) || (r < lo);
        res.val = (r > hi) ? hi : ((r < lo) ? lo : r);
        return res;
    endfunction

endpackage

// File: rtl/mul_channel_scheduler_round_sat.sv
// Registered round/shift/saturate stage for one multiplier product.
module mul_round_sat
    import mul_channel_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH_Y = 32,
    parameter int unsigned SHIFT   = 14,
    parameter int unsigned WIDTH_O = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [WIDTH_Y-1:0] y_i,
    output logic [WIDTH_O-1:0] r_o,
    output logic               sat_o
);

    rs_t  res;
    logic unused_hi;

    always_comb res = round_sat(64'(signed'(y_i)), SHIFT, WIDTH_O);

    assign unused_hi = ^res.val[63:WIDTH_O];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_o   <= '0;
            sat_o <= 1'b0;
        end else if (en_i) begin
            r_o   <= res.val[WIDTH_O-1:0];
            sat_o <= res.sat;
        end
    end

endmodule

// File: rtl/mul_channel_scheduler.sv
// Snapshots CHANNELS sample/gain pairs per trigger and runs them through one shared multiplier.
module mul_channel_scheduler
    import mul_channel_scheduler_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH_A  = 16,
    parameter int unsigned WIDTH_B  = 16,
    parameter int unsigned SHIFT    = 14,
    parameter int unsigned WIDTH_O  = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          trigger_i,
    input  logic [CHANNELS*WIDTH_A-1:0]   sample_i,
    input  logic [CHANNELS*WIDTH_B-1:0]   gain_i,
    output logic                          mul_start_o,
    output logic [WIDTH_A-1:0]            mul_A_o,
    output logic [WIDTH_B-1:0]            mul_B_o,
    input  logic [WIDTH_A+WIDTH_B-1:0]    mul_Y_i,
    input  logic                          mul_rdy_i,
    output logic [CHANNELS*WIDTH_O-1:0]   result_o,
    output logic [CHANNELS-1:0]           sat_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overrun_o
);

    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t              state_q, state_d;
    logic [CW-1:0]       chan_q;
    logic [WIDTH_A-1:0]  samp_q [CHANNELS];
    logic [WIDTH_B-1:0]  gain_q [CHANNELS];
    logic [WIDTH_O-1:0]  shadow_res_q [CHANNELS];
    logic [CHANNELS-1:0] shadow_sat_q;
    logic [WIDTH_O-1:0]  rs_val;
    logic                rs_sat;
    logic                last_chan;
    logic                capture_y;

    assign last_chan   = (chan_q == CW'(CHANNELS - 1));
    assign capture_y   = (state_q == WAIT_HI) && mul_rdy_i;
    assign mul_start_o = (state_q == LOAD);
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign mul_A_o     = samp_q[chan_q];
    assign mul_B_o     = gain_q[chan_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trigger_i) state_d = LOAD;
            LOAD:    state_d = WAIT_LO;
            WAIT_LO: if (!mul_rdy_i) state_d = WAIT_HI;
            WAIT_HI: if (mul_rdy_i) state_d = STORE;
            STORE:   state_d = last_chan ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mul_round_sat #(
        .WIDTH_Y (WIDTH_A + WIDTH_B),
        .SHIFT   (SHIFT),
        .WIDTH_O (WIDTH_O)
    ) u_round_sat (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (capture_y),
        .y_i       (mul_Y_i),
        .r_o       (rs_val),
        .sat_o     (rs_sat)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            chan_q       <= '0;
            shadow_sat_q <= '0;
            result_o     <= '0;
            sat_o        <= '0;
            overrun_o    <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                samp_q[k]       <= '0;
                gain_q[k]       <= '0;
                shadow_res_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            overrun_o <= trigger_i && (state_q != IDLE);
            if (state_q == IDLE && trigger_i) begin
                chan_q <= '0;
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    samp_q[k] <= sample_i[k*WIDTH_A +: WIDTH_A];
                    gain_q[k] <= gain_i[k*WIDTH_B +: WIDTH_B];
                end
            end
            if (state_q == STORE) begin
                shadow_res_q[chan_q] <= rs_val;
                shadow_sat_q[chan_q] <= rs_sat;
                // Publish on entry to DONE, bypassing the last channel, so outputs are valid with done_o.
                if (last_chan) begin
                    for (int unsigned k = 0; k < CHANNELS; k++) begin
                        result_o[k*WIDTH_O +: WIDTH_O] <= (CW'(k) == chan_q) ? rs_val : shadow_res_q[k];
                        sat_o[k] <= (CW'(k) == chan_q) ? rs_sat : shadow_sat_q[k];
                    end
                end else begin
                    chan_q <= chan_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_channel_scheduler.sv
// Self-checking bench: table vectors, hand sequences and random frames against a behavioural model.
module tb_mul_channel_scheduler;

    localparam int CH  = 4;
    localparam int WA  = 16;
    localparam int WB  = 16;
    localparam int SH  = 14;
    localparam int WO  = 16;
    localparam int LM  = 17;
    localparam int LAT = 1 + CH * (LM + 2);

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 trigger = 1'b0;
    logic [CH*WA-1:0]     sample = '0;
    logic [CH*WB-1:0]     gain = '0;
    logic                 mul_start;
    logic [WA-1:0]        mul_A;
    logic [WB-1:0]        mul_B;
    logic [WA+WB-1:0]     mul_Y;
    logic                 mul_rdy;
    logic [CH*WO-1:0]     result;
    logic [CH-1:0]        sat;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;

    mul_channel_scheduler #(
        .CHANNELS (CH),
        .WIDTH_A  (WA),
        .WIDTH_B  (WB),
        .SHIFT    (SH),
        .WIDTH_O  (WO)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .trigger_i   (trigger),
        .sample_i    (sample),
        .gain_i      (gain),
        .mul_start_o (mul_start),
        .mul_A_o     (mul_A),
        .mul_B_o     (mul_B),
        .mul_Y_i     (mul_Y),
        .mul_rdy_i   (mul_rdy),
        .result_o    (result),
        .sat_o       (sat),
        .busy_o      (busy),
        .done_o      (done),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    // Serial multiplier stand-in: rdy drops after start, product appears LM cycles after the start cycle.
    logic [WA-1:0] m_a;
    logic [WB-1:0] m_b;
    int            m_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_rdy <= 1'b1;
            mul_Y   <= '0;
            m_cnt   <= 0;
            m_a     <= '0;
            m_b     <= '0;
        end else if (mul_start) begin
            mul_rdy <= 1'b0;
            m_cnt   <= LM - 1;
            mul_Y   <= 32'hDEAD_BEEF;
            m_a     <= mul_A;
            m_b     <= mul_B;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_rdy <= 1'b1;
                mul_Y   <= 32'(longint'($signed(m_a)) * longint'(m_b));
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (overrun) ovr_cnt++;
    end

    typedef struct packed {
        logic [63:0] s;
        logic [63:0] g;
        logic [63:0] r;
        logic [3:0]  sat;
    } vec_t;

    function automatic logic [63:0] p4(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    // Reference: exact product, floor((y + half) / 2^SH), clamp to 16-bit signed.
    function automatic void model(input logic [63:0] s, input logic [63:0] g,
                                  output logic [63:0] r, output logic [3:0] st);
        longint y, n, d, q;
        r  = '0;
        st = '0;
        d  = longint'(1) << SH;
        for (int k = 0; k < CH; k++) begin
            y = longint'($signed(s[k*16 +: 16])) * longint'(g[k*16 +: 16]);
            n = y + d / 2;
            q = n / d;
            if ((n % d) < 0) q = q - 1;
            if (q > 32767) begin
                q = 32767;
                st[k] = 1'b1;
            end else if (q < -32768) begin
                q = -32768;
                st[k] = 1'b1;
            end
            r[k*16 +: 16] = 16'(q);
        end
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] er, input logic [3:0] es);
        for (int k = 0; k < CH; k++)
            chk($sformatf("%s result[%0d]", tag, k),
                longint'($signed(result[k*16 +: 16])), longint'($signed(er[k*16 +: 16])));
        chk({tag, " sat"}, longint'(sat), longint'(es));
    endtask

    // Returns at the negedge of the done cycle; lat = cycles from trigger cycle, -1 on timeout.
    task automatic run_frame(input logic [63:0] s, input logic [63:0] g, output int lat);
        @(posedge clk);
        #1;
        sample  = s;
        gain    = g;
        trigger = 1'b1;
        lat     = -1;
        for (int n = 1; n <= LAT + 50; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) trigger = 1'b0;
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v [4];
        int          lat;
        int          d0, o0, starts;
        logic [63:0] er, s, g, s2, g2;
        logic [3:0]  es;

        v[0] = '{p4(1000, -1000, 0, 32767), p4(16384, 16384, 16384, 16384),
                 p4(1000, -1000, 0, 32767), 4'b0000};
        v[1] = '{p4(-3, 3, 0, -32768), p4(8192, 8192, 0, 65535),
                 p4(-1, 2, 0, -32768), 4'b1000};
        v[2] = '{p4(32767, -32768, 100, -100), p4(32768, 32768, 16383, 16385),
                 p4(32767, -32768, 100, -100), 4'b0011};
        v[3] = '{p4(1, -1, 2, -2), p4(8192, 8192, 8192, 8192),
                 p4(1, 0, 1, -1), 4'b0000};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset result", longint'(result), 0);
        chk("reset sat", longint'(sat), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        chk("reset start", longint'(mul_start), 0);
        chk("reset overrun", longint'(overrun), 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(v[i].s, v[i].g, lat);
            chk($sformatf("vec%0d latency", i), lat, LAT);
            check_frame($sformatf("vec%0d", i), v[i].r, v[i].sat);
            @(negedge clk);
            chk($sformatf("vec%0d done single", i), longint'(done), 0);
            check_frame($sformatf("vec%0d hold", i), v[i].r, v[i].sat);
        end

        // Overrun 10 cycles in, input change 5 cycles in: frame must use the trigger snapshot.
        s  = p4(1234, -5678, 30000, -1);
        g  = p4(16384, 20000, 12000, 65535);
        s2 = p4(-1, 7, 9, 11);
        g2 = p4(100, 200, 300, 400);
        model(s, g, er, es);
        d0 = done_cnt;
        o0 = ovr_cnt;
        @(posedge clk);
        #1;
        sample  = s;
        gain    = g;
        trigger = 1'b1;
        lat     = -1;
        for (int n = 1; n <= LAT + 50; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) trigger = 1'b0;
            if (n == 5) begin
                sample = s2;
                gain   = g2;
            end
            if (n == 10) trigger = 1'b1;
            if (n == 11) trigger = 1'b0;
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("overrun latency", lat, LAT);
        check_frame("overrun snapshot", er, es);
        repeat (90) @(negedge clk);
        chk("overrun pulses", ovr_cnt - o0, 1);
        chk("overrun done count", done_cnt - d0, 1);

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < CH; k++) begin
                case ($urandom_range(0, 5))
                    0:       s[k*16 +: 16] = 16'h8000;
                    1:       s[k*16 +: 16] = 16'h7FFF;
                    default: s[k*16 +: 16] = 16'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0:       g[k*16 +: 16] = 16'h0000;
                    1:       g[k*16 +: 16] = 16'hFFFF;
                    2:       g[k*16 +: 16] = 16'h4000;
                    default: g[k*16 +: 16] = 16'($urandom);
                endcase
            end
            model(s, g, er, es);
            run_frame(s, g, lat);
            chk($sformatf("rand%0d latency", i), lat, LAT);
            check_frame($sformatf("rand%0d", i), er, es);
        end

        // Trigger during the done cycle is an overrun and starts nothing.
        run_frame(v[0].s, v[0].g, lat);
        chk("donetrig latency", lat, LAT);
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        chk("donetrig overrun", longint'(overrun), 1);
        chk("donetrig busy", longint'(busy), 0);
        @(negedge clk);
        chk("donetrig overrun end", longint'(overrun), 0);
        chk("donetrig busy end", longint'(busy), 0);

        // Asynchronous reset while the second channel waits for rdy.
        @(posedge clk);
        #1;
        sample  = p4(500, 600, 700, 800);
        gain    = p4(16384, 16384, 16384, 16384);
        trigger = 1'b1;
        starts  = 0;
        for (int n = 1; n <= LAT + 50; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) trigger = 1'b0;
            @(negedge clk);
            if (mul_start) starts++;
            if (starts == 2) break;
        end
        repeat (5) @(negedge clk);
        chk("midreset busy before", longint'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset result", longint'(result), 0);
        chk("midreset sat", longint'(sat), 0);
        chk("midreset busy", longint'(busy), 0);
        chk("midreset done", longint'(done), 0);
        chk("midreset start", longint'(mul_start), 0);
        chk("midreset opA", longint'(mul_A), 0);
        chk("midreset opB", longint'(mul_B), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        s = p4(-20000, 12345, -7, 32767);
        g = p4(24576, 8000, 40000, 16385);
        model(s, g, er, es);
        run_frame(s, g, lat);
        chk("postreset latency", lat, LAT);
        check_frame("postreset", er, es);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
